// File: rtl/operand_sequencer.sv
// rtl/operand_sequencer.sv - operand/result sequencer for the A*X^2+B*X+C datapath
// Optional one-entry operand skid buffer enabled by defining SEQ_SKID_EN.
module operand_sequencer #(
  parameter int LATENCY = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_x,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  input  logic [7:0]  in_c,
  output logic [7:0]  X,
  output logic [7:0]  A,
  output logic [7:0]  B,
  output logic [7:0]  C,
  output logic        INICIO,
  input  logic [15:0] RESULT,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data
);

  typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;

  state_t      state, state_nx;
  logic [7:0]  cnt;
  logic        acc;
  logic        load_in;
  logic        load_buf;

`ifdef SEQ_SKID_EN
  logic        buf_full;
  logic        buf_fill;
  logic [31:0] buf_ops;
`endif

  always_comb begin
    state_nx  = state;
    load_in   = 1'b0;
    load_buf  = 1'b0;
    INICIO    = 1'b0;
    res_valid = 1'b0;
`ifdef SEQ_SKID_EN
    in_ready  = !buf_full;
`else
    in_ready  = (state == IDLE);
`endif
    acc = in_valid && in_ready;
    case (state)
      IDLE: begin
        if (acc) begin
          load_in  = 1'b1;
          state_nx = START;
        end
      end
      START: begin
        INICIO   = 1'b1;
        state_nx = WAIT;
      end
      WAIT: begin
        if (cnt == 8'd0) state_nx = OUT;
      end
      OUT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_nx = IDLE;
`ifdef SEQ_SKID_EN
          // A set arriving on the handshake cycle itself bypasses the buffer.
          if (buf_full) begin
            load_buf = 1'b1;
            state_nx = START;
          end else if (acc) begin
            load_in  = 1'b1;
            state_nx = START;
          end
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
`ifdef SEQ_SKID_EN
    buf_fill = acc && !load_in;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      X        <= 8'd0;
      A        <= 8'd0;
      B        <= 8'd0;
      C        <= 8'd0;
      res_data <= 16'd0;
    end else begin
      state <= state_nx;
      // Loaded with LATENCY-1 so the zero test lands LATENCY cycles after START.
      if (state == START) begin
        cnt <= 8'(LATENCY - 1);
      end else if (state == WAIT && cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
      if (state == WAIT && cnt == 8'd0) res_data <= RESULT;
      if (load_in) begin
        {X, A, B, C} <= {in_x, in_a, in_b, in_c};
`ifdef SEQ_SKID_EN
      end else if (load_buf) begin
        {X, A, B, C} <= buf_ops;
`endif
      end
    end
  end

`ifdef SEQ_SKID_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full <= 1'b0;
      buf_ops  <= 32'd0;
    end else if (buf_fill) begin
      buf_full <= 1'b1;
      buf_ops  <= {in_x, in_a, in_b, in_c};
    end else if (load_buf) begin
      buf_full <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_operand_sequencer.sv
// tb/tb_operand_sequencer.sv - directed self-checking bench for operand_sequencer
module tb_operand_sequencer;

  localparam int LAT = 10;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [7:0]  in_x, in_a, in_b, in_c;
  logic [7:0]  X, A, B, C;
  logic        INICIO;
  logic [15:0] RESULT;
  logic        res_valid, res_ready;
  logic [15:0] res_data;

  logic        in_valid2, in_ready2;
  logic [7:0]  in_x2, in_a2, in_b2, in_c2;
  logic [7:0]  X2, A2, B2, C2;
  logic        INICIO2;
  logic [15:0] RESULT2;
  logic        res_valid2, res_ready2;
  logic [15:0] res_data2;

  int checks = 0;
  int errors = 0;
  int tc = 0;
  int tc2 = 0;

  operand_sequencer #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .X(X), .A(A), .B(B), .C(C), .INICIO(INICIO), .RESULT(RESULT),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  operand_sequencer #(.LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_x(in_x2), .in_a(in_a2), .in_b(in_b2), .in_c(in_c2),
    .X(X2), .A(A2), .B(B2), .C(C2), .INICIO(INICIO2), .RESULT(RESULT2),
    .res_valid(res_valid2), .res_ready(res_ready2), .res_data(res_data2)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] poly(input logic [7:0] x, a, b, c);
    logic [15:0] x16, a16, b16, c16;
    x16 = {8'd0, x};
    a16 = {8'd0, a};
    b16 = {8'd0, b};
    c16 = {8'd0, c};
    return a16 * x16 * x16 + b16 * x16 + c16;
  endfunction

  // Datapath model: RESULT is only correct exactly LATENCY cycles after INICIO.
  always @(posedge clk) begin
    if (rst) tc <= 0;
    else if (INICIO) tc <= 1;
    else if (tc != 0 && tc < 1000) tc <= tc + 1;
    if (rst) tc2 <= 0;
    else if (INICIO2) tc2 <= 1;
    else if (tc2 != 0 && tc2 < 1000) tc2 <= tc2 + 1;
  end
  assign RESULT  = (tc == LAT) ? poly(X, A, B, C) : 16'hDEAD;
  assign RESULT2 = (tc2 == 2) ? poly(X2, A2, B2, C2) : 16'hDEAD;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers a set, returns cycles accept->INICIO, INICIO->res_valid and extra INICIO pulses.
  task automatic offer(input logic [7:0] x, a, b, c,
                       output int acc_to_inicio, output int inicio_to_valid, output int extra);
    int n;
    in_x = x; in_a = a; in_b = b; in_c = c;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin tick(); n++; end
    tick();
    in_valid = 1'b0;
    acc_to_inicio = 1;
    while (!INICIO && acc_to_inicio < 200) begin tick(); acc_to_inicio++; end
    inicio_to_valid = 0;
    extra = 0;
    while (!res_valid && inicio_to_valid < 300) begin
      tick();
      inicio_to_valid++;
      if (INICIO) extra++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++;
    if (INICIO !== 1'b0) begin errors++; $display("FAIL reset_inicio got %b want 0", INICIO); end
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    checks++;
    if (res_data !== 16'h0000) begin errors++; $display("FAIL reset_res_data got %h want 0000", res_data); end
    checks++;
    if ({X, A, B, C} !== 32'h0) begin errors++; $display("FAIL reset_operands got %h want 00000000", {X, A, B, C}); end
  endtask

  task automatic test_basic();
    int ai, iv, ex;
    res_ready = 1'b1;
    offer(8'd2, 8'd3, 8'd1, 8'd7, ai, iv, ex);
    checks++;
    if (ai !== 1) begin errors++; $display("FAIL basic_accept_to_inicio got %0d want 1", ai); end
    checks++;
    if (iv !== LAT + 1) begin errors++; $display("FAIL basic_inicio_to_valid got %0d want %0d", iv, LAT + 1); end
    checks++;
    if (ex !== 0) begin errors++; $display("FAIL basic_extra_inicio got %0d want 0", ex); end
    checks++;
    if (res_data !== 16'h0015) begin errors++; $display("FAIL basic_res_data got %h want 0015", res_data); end
    tick();
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL basic_back_to_idle got valid=%b ready=%b want valid=0 ready=1", res_valid, in_ready);
    end
  endtask

  task automatic test_hold();
    int ai, iv, ex;
    res_ready = 1'b0;
    offer(8'd2, 8'd3, 8'd1, 8'd7, ai, iv, ex);
    checks++;
    if (iv !== LAT + 1) begin errors++; $display("FAIL hold_inicio_to_valid got %0d want %0d", iv, LAT + 1); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_data !== 16'h0015) begin
        errors++; $display("FAIL hold_stable cycle %0d got valid=%b data=%h want valid=1 data=0015", i, res_valid, res_data);
      end
    end
    checks++;
    if ({X, A, B, C} !== 32'h02030107) begin errors++; $display("FAIL hold_operands got %h want 02030107", {X, A, B, C}); end
    res_ready = 1'b1;
    tick();
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL hold_release got valid=%b ready=%b want valid=0 ready=1", res_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int n, seen, ai, iv, ex;
    res_ready = 1'b1;
    in_x = 8'd2; in_a = 8'd3; in_b = 8'd1; in_c = 8'd7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({X, A, B, C} !== 32'h0 || res_data !== 16'h0 || res_valid !== 1'b0 || INICIO !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs got ops=%h data=%h valid=%b inicio=%b want all zero",
                         {X, A, B, C}, res_data, res_valid, INICIO);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready got %b want 1", in_ready); end
    seen = 0;
    for (n = 0; n < LAT + 5; n++) begin
      tick();
      if (res_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL midreset_no_valid got %0d want 0", seen); end
    offer(8'd1, 8'd1, 8'd1, 8'd1, ai, iv, ex);
    checks++;
    if (iv !== LAT + 1) begin errors++; $display("FAIL midreset_latency got %0d want %0d", iv, LAT + 1); end
    checks++;
    if (res_data !== 16'h0003) begin errors++; $display("FAIL midreset_res_data got %h want 0003", res_data); end
    tick();
  endtask

`ifndef SEQ_SKID_EN
  task automatic test_no_skid();
    int accepts, pulses, readies, overlap;
    accepts = 0; pulses = 0; readies = 0; overlap = 0;
    res_ready = 1'b1;
    in_x = 8'd1; in_a = 8'd1; in_b = 8'd1; in_c = 8'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 3 * (LAT + 3); i++) begin
      if (in_ready) readies++;
      if (in_ready && in_valid) accepts++;
      if (INICIO) pulses++;
      if (in_ready && (INICIO || res_valid)) overlap++;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (accepts !== 3) begin errors++; $display("FAIL noskid_accepts got %0d want 3", accepts); end
    checks++;
    if (pulses !== 3) begin errors++; $display("FAIL noskid_inicio got %0d want 3", pulses); end
    checks++;
    if (readies !== 3) begin errors++; $display("FAIL noskid_ready_cycles got %0d want 3", readies); end
    checks++;
    if (overlap !== 0) begin errors++; $display("FAIL noskid_ready_outside_idle got %0d want 0", overlap); end
  endtask
`else
  task automatic test_skid();
    int n;
    res_ready = 1'b1;
    in_x = 8'd2; in_a = 8'd3; in_b = 8'd1; in_c = 8'd7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    in_x = 8'd3; in_a = 8'd0; in_b = 8'd2; in_c = 8'd1;
    in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_in_wait got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL skid_ready_full got %b want 0", in_ready); end
    checks++;
    if ({X, A, B, C} !== 32'h02030107) begin errors++; $display("FAIL skid_ops_held got %h want 02030107", {X, A, B, C}); end
    n = 0;
    while (!res_valid && n < 300) begin tick(); n++; end
    checks++;
    if (res_data !== 16'h0015) begin errors++; $display("FAIL skid_first_result got %h want 0015", res_data); end
    tick();
    checks++;
    if (INICIO !== 1'b1 || {X, A, B, C} !== 32'h03000201) begin
      errors++; $display("FAIL skid_direct_start got inicio=%b ops=%h want inicio=1 ops=03000201", INICIO, {X, A, B, C});
    end
    n = 0;
    while (!res_valid && n < 300) begin tick(); n++; end
    checks++;
    if (n !== LAT + 1) begin errors++; $display("FAIL skid_second_latency got %0d want %0d", n, LAT + 1); end
    checks++;
    if (res_data !== 16'h0007) begin errors++; $display("FAIL skid_second_result got %h want 0007", res_data); end
    tick();
  endtask
`endif

  task automatic test_latency2();
    int n;
    res_ready2 = 1'b1;
    for (int r = 0; r < 2; r++) begin
      if (r == 0) begin in_x2 = 8'd1; in_a2 = 8'd1; in_b2 = 8'd1; in_c2 = 8'd1; end
      else begin in_x2 = 8'd3; in_a2 = 8'd0; in_b2 = 8'd2; in_c2 = 8'd1; end
      in_valid2 = 1'b1;
      n = 0;
      while (!in_ready2 && n < 50) begin tick(); n++; end
      tick();
      in_valid2 = 1'b0;
      checks++;
      if (INICIO2 !== 1'b1) begin errors++; $display("FAIL lat2_inicio run %0d got %b want 1", r, INICIO2); end
      n = 0;
      while (!res_valid2 && n < 100) begin tick(); n++; end
      checks++;
      if (n !== 3) begin errors++; $display("FAIL lat2_latency run %0d got %0d want 3", r, n); end
      checks++;
      if (res_data2 !== (r == 0 ? 16'h0003 : 16'h0007)) begin
        errors++; $display("FAIL lat2_result run %0d got %h want %h", r, res_data2, (r == 0 ? 16'h0003 : 16'h0007));
      end
      tick();
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    in_valid = 1'b0; in_x = 8'd0; in_a = 8'd0; in_b = 8'd0; in_c = 8'd0;
    res_ready = 1'b1;
    in_valid2 = 1'b0; in_x2 = 8'd0; in_a2 = 8'd0; in_b2 = 8'd0; in_c2 = 8'd0;
    res_ready2 = 1'b1;
    test_reset();
    test_basic();
    test_hold();
    test_reset_mid();
`ifdef SEQ_SKID_EN
    test_skid();
`else
    test_no_skid();
`endif
    test_latency2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
